apb_reg_bridge: RTL and testbench
=================================

APB_REG_BRIDGE -- requirements
Module: apb_reg_bridge

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 64, address width; DATA_WIDTH, 32, data width (fixed at 32, pstrb is 4 bits).
REQ-002 Clock and reset SHALL be one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous, active-high reset.
REQ-003 APB slave ports SHALL be:
- psel  in  1
- penable  in  1
- pwrite  in  1
- paddr  in  ADDR_WIDTH
- pwdata  in  DATA_WIDTH
- pstrb  in  4
- pready  out  1
- prdata  out  DATA_WIDTH
- pslverr  out  1
REQ-004 Register-side request ports SHALL be:
- req_vld  out  1  request valid
- req_rdy  in  1  master FSM ready
- rd_en  out  1
- wr_en  out  1
- addr  out  ADDR_WIDTH
- wr_data  out  DATA_WIDTH
REQ-005 Register-side response ports SHALL be:
- ack_vld  in  1
- ack_rdy  out  1
- rd_data  in  DATA_WIDTH
- timeout_err  in  1  master timeout flag, sampled with ack_vld
REQ-006 Status ports SHALL be: err_clear  in  1  clears err_cnt; err_cnt  out  16  saturating error count.

Function
REQ-007 The FSM SHALL have the states IDLE, REQ, WAIT_ACK, RESP and ERR; all outputs SHALL be registered.
REQ-008 In IDLE, psel=1 & penable=0 SHALL capture paddr, pwrite, pwdata and pstrb; next state SHALL be ERR if paddr[1:0]!=0 or (pwrite & pstrb!=4'hF), else REQ.
REQ-009 In REQ, the block SHALL drive req_vld=1, rd_en=!pwrite_q, wr_en=pwrite_q, addr=paddr_q, wr_data=pwdata_q, all held stable until the cycle with req_vld&req_rdy; it SHALL then go to WAIT_ACK and deassert req_vld, rd_en and wr_en on the next edge.
REQ-010 In WAIT_ACK, the block SHALL drive ack_rdy=1; on ack_vld it SHALL load prdata with rd_data for reads and 0 for writes, load pslverr with timeout_err, and go to RESP.
REQ-011 In RESP, the block SHALL drive pready=1 for exactly one cycle and then return to IDLE, clearing pready, pslverr and prdata.
REQ-012 In ERR, the block SHALL drive pready=1, pslverr=1 and prdata=0 for one cycle and issue no req_vld, then return to IDLE.
REQ-013 Minimum latency SHALL be: setup at cycle T, req_vld at T+1, and with req_rdy=1 at T+1 and ack_vld=1 at T+2, pready=1 at T+3.
REQ-014 pready SHALL stay 0 in every state other than RESP and ERR, inserting APB wait states for any req_rdy or ack_vld stall.
REQ-015 If psel drops before pready (protocol violation), the register transaction SHALL still complete, the response SHALL be discarded (pready still pulses) and the FSM SHALL return to IDLE.
REQ-016 A new setup SHALL be accepted only in IDLE; back-to-back transfers SHALL have at least one IDLE cycle between them.
REQ-017 err_cnt SHALL increment by 1 on each ERR entry and each RESP with pslverr=1, and SHALL saturate at 16'hFFFF.
REQ-018 err_clear SHALL zero err_cnt; when err_clear coincides with an error event, err_clear SHALL win.
REQ-019 An ack_vld received outside WAIT_ACK SHALL be ignored.

Reset
REQ-020 While rst=1, the FSM SHALL be in IDLE and all outputs (pready, pslverr, prdata, req_vld, rd_en, wr_en, addr, wr_data, ack_rdy, err_cnt) SHALL be 0, asynchronously.
REQ-021 A reset asserted mid-transfer SHALL abort the transfer immediately, with no response pulse after reset release.

Structure
REQ-022 Package apb_reg_bridge_pkg SHALL hold the state enum (3-bit) and the constants ERR_CNT_MAX=16'hFFFF and FULL_STRB=4'hF.
REQ-023 The block SHALL be a single module with no sub-module.

Verification
REQ-024 Read: setup paddr=0x100, pwrite=0, with req_rdy=1 and ack_vld at T+2 carrying rd_data=0x12345678 -> addr=0x100, rd_en=1 at T+1, pready=1 at T+3, prdata=0x12345678, pslverr=0.
REQ-025 Write with stall: paddr=0x104, pwdata=0xA5A5A5A5, req_rdy=0 for 3 cycles -> req_vld and wr_data held stable for 4 cycles, pready=1 exactly one cycle after ack_vld, prdata=0.
REQ-026 Timeout: ack_vld with timeout_err=1 and rd_data=0xDEADBEEF -> pslverr=1, prdata=0xDEADBEEF, err_cnt=1.
REQ-027 Illegal access: paddr=0x102 (misaligned), or a write with pstrb=4'h3 -> ERR, pready=pslverr=1 at T+1, req_vld never asserted, err_cnt incremented.
REQ-028 Saturation/clear: force 65536 errors -> err_cnt=0xFFFF; err_clear asserted together with an error -> err_cnt=0.
REQ-029 Reset mid-WAIT_ACK: rst pulse -> all outputs 0 immediately; a later ack_vld is ignored and the next transfer completes normally.

Source files
------------

// File: rtl/apb_reg_bridge_pkg.sv
// Shared types and constants for the APB-to-register-bus bridge.
package apb_reg_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWaitAck,
    StResp,
    StErr
  } state_e;

  localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;
  localparam logic [3:0]  FULL_STRB   = 4'hF;

endpackage

// File: rtl/apb_reg_bridge_if.sv
// APB slave bus plus the register-side request/response handshake.
interface apb_reg_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 32
);

  // APB
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [3:0]            pstrb;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

  // Register-side request
  logic                  req_vld;
  logic                  req_rdy;
  logic                  rd_en;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data;

  // Register-side response
  logic                  ack_vld;
  logic                  ack_rdy;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  timeout_err;

  // Bridge side
  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output pready, prdata, pslverr,
    output req_vld, rd_en, wr_en, addr, wr_data,
    input  req_rdy,
    input  ack_vld, rd_data, timeout_err,
    output ack_rdy
  );

  // APB master / register-bus responder side
  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  pready, prdata, pslverr,
    input  req_vld, rd_en, wr_en, addr, wr_data,
    output req_rdy,
    output ack_vld, rd_data, timeout_err,
    input  ack_rdy
  );

endinterface

// File: rtl/apb_reg_bridge.sv
// APB slave that turns each legal transfer into one register-bus request/response
// pair. Misaligned or partial-strobe writes are rejected locally with pslverr.
// Every output comes straight from a flop; next values are derived from state_d.
module apb_reg_bridge
  import apb_reg_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  apb_reg_bridge_if.slave bus,
  input  logic        err_clear,
  output logic [15:0] err_cnt
);

  state_e                state_q, state_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pslverr_q, pslverr_d;
  logic                  pready_q, pready_d;
  logic                  req_vld_q, req_vld_d;
  logic                  rd_en_q, rd_en_d;
  logic                  wr_en_q, wr_en_d;
  logic                  ack_rdy_q, ack_rdy_d;
  logic [15:0]           err_cnt_q, err_cnt_d;
  logic                  err_evt;

  // Next state, captured transfer fields and registered output values
  always_comb begin
    state_d   = state_q;
    pwrite_d  = pwrite_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;
    err_evt   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.psel && !bus.penable) begin
          pwrite_d  = bus.pwrite;
          addr_d    = bus.paddr;
          wr_data_d = bus.pwdata;
          if ((bus.paddr[1:0] != 2'b00) || (bus.pwrite && (bus.pstrb != FULL_STRB))) begin
            state_d = StErr;
            err_evt = 1'b1;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (req_vld_q && bus.req_rdy) begin
          state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        if (bus.ack_vld) begin
          prdata_d  = pwrite_q ? '0 : bus.rd_data;
          pslverr_d = bus.timeout_err;
          err_evt   = bus.timeout_err;
          state_d   = StResp;
        end
      end
      StResp:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Local rejects answer with an error and no data; IDLE clears the response.
    if (state_d == StErr) begin
      pslverr_d = 1'b1;
      prdata_d  = '0;
    end else if (state_d == StIdle) begin
      pslverr_d = 1'b0;
      prdata_d  = '0;
    end

    pready_d  = (state_d == StResp) || (state_d == StErr);
    req_vld_d = (state_d == StReq);
    rd_en_d   = req_vld_d && !pwrite_d;
    wr_en_d   = req_vld_d && pwrite_d;
    ack_rdy_d = (state_d == StWaitAck);

    // Clear beats a coincident error; the count sticks at its maximum.
    if (err_clear) begin
      err_cnt_d = '0;
    end else if (err_evt && (err_cnt_q != ERR_CNT_MAX)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pwrite_q  <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      pready_q  <= 1'b0;
      req_vld_q <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      ack_rdy_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pwrite_q  <= pwrite_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      pready_q  <= pready_d;
      req_vld_q <= req_vld_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      ack_rdy_q <= ack_rdy_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.pready  = pready_q;
  assign bus.prdata  = prdata_q;
  assign bus.pslverr = pslverr_q;
  assign bus.req_vld = req_vld_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.addr    = addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.ack_rdy = ack_rdy_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Self-checking bench for apb_reg_bridge: directed cases plus random transfers,
// checked cycle by cycle against a transaction-level expectation.
module tb_apb_reg_bridge;

  logic        clk;
  logic        rst;
  logic        err_clear;
  logic [15:0] err_cnt;

  int          n_vec;
  int          n_fail;
  int unsigned exp_cnt;

  apb_reg_bridge_if #(.ADDR_WIDTH(64), .DATA_WIDTH(32)) bus ();

  apb_reg_bridge #(
    .ADDR_WIDTH(64),
    .DATA_WIDTH(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .err_clear(err_clear),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void bump_err(input logic clr);
    if (clr) exp_cnt = 0;
    else if (exp_cnt < 32'hFFFF) exp_cnt = exp_cnt + 1;
  endfunction

  // One APB transfer. Inputs are driven and outputs sampled at the falling edge.
  // rstall: cycles req_rdy is held low; adly: WAIT_ACK cycles before ack_vld;
  // clr: pulse err_clear on the cycle of the error event; viol: drop psel early.
  task automatic xfer(input logic [63:0] a, input logic w, input logic [31:0] wd,
                      input logic [3:0] st, input int rstall, input int adly,
                      input logic [31:0] rd, input logic tmo, input logic clr,
                      input logic viol);
    logic illegal;
    illegal = (a[1:0] != 2'b00) || (w && (st != 4'hF));
    // Setup cycle T; stray req_rdy/ack_vld in IDLE must be ignored
    bus.psel        = 1'b1;
    bus.penable     = 1'b0;
    bus.pwrite      = w;
    bus.paddr       = a;
    bus.pwdata      = wd;
    bus.pstrb       = st;
    bus.req_rdy     = 1'($urandom % 2);
    bus.ack_vld     = 1'($urandom % 2);
    bus.rd_data     = $urandom;
    bus.timeout_err = 1'($urandom % 2);
    err_clear       = illegal && clr;
    @(negedge clk);
    bus.penable = 1'b1;
    err_clear   = 1'b0;
    if (illegal) begin
      bump_err(clr);
      check("err_pready", bus.pready, 1);
      check("err_pslverr", bus.pslverr, 1);
      check("err_prdata", bus.prdata, 0);
      check("err_req_vld", bus.req_vld, 0);
      check("err_cnt_ill", err_cnt, exp_cnt);
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
      @(negedge clk);
      check("err_pready_off", bus.pready, 0);
      check("err_req_vld_after", bus.req_vld, 0);
    end else begin
      for (int i = 0; i <= rstall; i++) begin
        check("req_vld", bus.req_vld, 1);
        check("req_addr", bus.addr, a);
        check("req_rd_en", bus.rd_en, !w);
        check("req_wr_en", bus.wr_en, w);
        check("req_wr_data", bus.wr_data, wd);
        check("req_pready", bus.pready, 0);
        check("req_ack_rdy", bus.ack_rdy, 0);
        bus.req_rdy = (i == rstall);
        bus.ack_vld = 1'($urandom % 2);
        bus.rd_data = $urandom;
        if (viol) bus.psel = 1'b0;
        @(negedge clk);
      end
      for (int j = 0; j <= adly; j++) begin
        check("wait_req_vld", bus.req_vld, 0);
        check("wait_rd_en", bus.rd_en, 0);
        check("wait_wr_en", bus.wr_en, 0);
        check("wait_ack_rdy", bus.ack_rdy, 1);
        check("wait_pready", bus.pready, 0);
        bus.req_rdy     = 1'($urandom % 2);
        bus.ack_vld     = (j == adly);
        bus.rd_data     = (j == adly) ? rd : $urandom;
        bus.timeout_err = (j == adly) ? tmo : 1'($urandom % 2);
        err_clear       = (j == adly) && clr;
        @(negedge clk);
      end
      if (clr) exp_cnt = 0;
      else if (tmo) bump_err(1'b0);
      bus.ack_vld = 1'b0;
      err_clear   = 1'b0;
      check("resp_pready", bus.pready, 1);
      check("resp_prdata", bus.prdata, w ? 32'h0 : rd);
      check("resp_pslverr", bus.pslverr, tmo);
      check("resp_err_cnt", err_cnt, exp_cnt);
      check("resp_ack_rdy", bus.ack_rdy, 0);
      check("resp_req_vld", bus.req_vld, 0);
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
      @(negedge clk);
      check("idle_pready", bus.pready, 0);
      check("idle_prdata", bus.prdata, 0);
      check("idle_pslverr", bus.pslverr, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pready"}, bus.pready, 0);
    check({tag, "_pslverr"}, bus.pslverr, 0);
    check({tag, "_prdata"}, bus.prdata, 0);
    check({tag, "_req_vld"}, bus.req_vld, 0);
    check({tag, "_rd_en"}, bus.rd_en, 0);
    check({tag, "_wr_en"}, bus.wr_en, 0);
    check({tag, "_addr"}, bus.addr, 0);
    check({tag, "_wr_data"}, bus.wr_data, 0);
    check({tag, "_ack_rdy"}, bus.ack_rdy, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  initial begin
    logic [63:0] a;
    logic        w;
    logic [3:0]  st;
    n_vec   = 0;
    n_fail  = 0;
    exp_cnt = 0;
    rst             = 1'b1;
    err_clear       = 1'b0;
    bus.psel        = 1'b0;
    bus.penable     = 1'b0;
    bus.pwrite      = 1'b0;
    bus.paddr       = '0;
    bus.pwdata      = '0;
    bus.pstrb       = 4'h0;
    bus.req_rdy     = 1'b0;
    bus.ack_vld     = 1'b0;
    bus.rd_data     = '0;
    bus.timeout_err = 1'b0;
    #1;
    check_all_zero("rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Minimum-latency read
    xfer(64'h100, 1'b0, 32'h0, 4'hF, 0, 0, 32'h12345678, 1'b0, 1'b0, 1'b0);
    // Write with three stall cycles on req_rdy
    xfer(64'h104, 1'b1, 32'hA5A5A5A5, 4'hF, 3, 0, 32'h0, 1'b0, 1'b0, 1'b0);
    // Timeout on a read
    xfer(64'h108, 1'b0, 32'h0, 4'hF, 0, 1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    check("timeout_cnt_is_1", err_cnt, 1);
    // Misaligned address and partial-strobe write
    xfer(64'h102, 1'b0, 32'h0, 4'hF, 0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
    xfer(64'h10C, 1'b1, 32'h11, 4'h3, 0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("illegal_cnt_is_3", err_cnt, 3);
    // Protocol violation: psel dropped, transfer still completes
    xfer(64'h110, 1'b0, 32'h0, 4'hF, 2, 2, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1);

    // Saturation: preload near the top, then push past it
    @(negedge clk);
    force dut.err_cnt_q = 16'hFFFD;
    #1;
    release dut.err_cnt_q;
    exp_cnt = 32'hFFFD;
    for (int k = 0; k < 4; k++) begin
      xfer(64'h201, 1'b0, 32'h0, 4'hF, 0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
    end
    check("sat_cnt", err_cnt, 16'hFFFF);
    // err_clear coincident with an error wins
    xfer(64'h203, 1'b0, 32'h0, 4'hF, 0, 0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("clr_wins_ill", err_cnt, 0);
    xfer(64'h204, 1'b1, 32'h0, 4'hF, 0, 0, 32'h0, 1'b1, 1'b0, 1'b0);
    xfer(64'h208, 1'b0, 32'h0, 4'hF, 1, 1, 32'h5, 1'b1, 1'b1, 1'b0);
    check("clr_wins_tmo", err_cnt, 0);

    // Random transfers
    for (int n = 0; n < 80; n++) begin
      a = {$urandom, $urandom};
      if ($urandom % 4 != 0) a[1:0] = 2'b00;
      w  = 1'($urandom % 2);
      st = ($urandom % 5 == 0) ? 4'($urandom) : 4'hF;
      xfer(a, w, $urandom, st, int'($urandom % 5), int'($urandom % 5), $urandom,
           ($urandom % 4 == 0), ($urandom % 10 == 0), ($urandom % 8 == 0));
    end

    // Reset in WAIT_ACK: make err_cnt nonzero first
    xfer(64'h301, 1'b0, 32'h0, 4'hF, 0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = 64'h300;
    bus.pstrb   = 4'hF;
    bus.req_rdy = 1'b0;
    bus.ack_vld = 1'b0;
    @(negedge clk);
    bus.penable = 1'b1;
    bus.req_rdy = 1'b1;
    @(negedge clk);
    bus.req_rdy = 1'b0;
    check("pre_rst_ack_rdy", bus.ack_rdy, 1);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst             = 1'b0;
    bus.psel        = 1'b0;
    bus.penable     = 1'b0;
    bus.ack_vld     = 1'b1;
    bus.rd_data     = 32'h87654321;
    bus.timeout_err = 1'b1;
    exp_cnt         = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_pready", bus.pready, 0);
      check("post_rst_pslverr", bus.pslverr, 0);
      check("post_rst_ack_rdy", bus.ack_rdy, 0);
      check("post_rst_err_cnt", err_cnt, 0);
    end
    bus.ack_vld = 1'b0;
    xfer(64'h400, 1'b0, 32'h0, 4'hF, 1, 0, 32'h0BADF00D, 1'b0, 1'b0, 1'b0);
    xfer(64'h404, 1'b1, 32'h600DF00D, 4'hF, 0, 2, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
